lmul_uop_sequencer: RTL and testbench

Expands one decoded vector ALU instruction into LMUL register-group micro-ops, issuing one micro-op per cycle to the vector execute stage. It sits directly downstream of decode/grouping selection and directly upstream of the vector register-file read port. While a multi-register group is being expanded, it holds the upstream fetch/decode stages (IF1/IF2) with a stall.

---
 rtl/lmul_uop_sequencer.sv | 138 +++++++++++++
 tb/tb_lmul_uop_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lmul_uop_sequencer.sv
// Expands one decoded vector ALU instruction into LMUL register-group micro-ops,
// one per cycle, and stalls fetch/decode while a multi-register group drains.
module lmul_uop_sequencer #(
    parameter int unsigned REG_W    = 5,
    parameter int unsigned MAX_LMUL = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [REG_W-1:0] vs1,
    input  logic [REG_W-1:0] vs2,
    input  logic [REG_W-1:0] vd,
    input  logic [2:0]       lmul_enc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [REG_W-1:0] raA_out,
    output logic [REG_W-1:0] raB_out,
    output logic [REG_W-1:0] rdest_out,
    output logic [2:0]       uop_idx,
    output logic             uop_first,
    output logic             uop_last,
    output logic             illegal,
    output logic             fetch_stall
);

    typedef enum logic [0:0] {
        StIdle,
        StIssue
    } state_e;

    localparam logic [3:0] MaxLmul = 4'(MAX_LMUL);

    state_e           state_q, state_d;
    logic [REG_W-1:0] vs1_q, vs1_d;
    logic [REG_W-1:0] vs2_q, vs2_d;
    logic [REG_W-1:0] vd_q, vd_d;
    logic [2:0]       lmul_m1_q, lmul_m1_d;
    logic [2:0]       idx_q, idx_d;
    logic             illegal_q, illegal_d;

    logic             issue;
    logic             handshake;
    logic             is_last;
    logic             accept;
    logic [3:0]       lmul_dec;
    logic [REG_W-1:0] align_mask;
    logic             legal;

    // Legality of the instruction currently presented upstream.
    always_comb begin
        lmul_dec   = 4'd1 << lmul_enc[1:0];
        align_mask = REG_W'(lmul_dec - 4'd1);
        legal      = 1'b1;
        if (lmul_enc[2] || (lmul_dec > MaxLmul)) begin
            legal = 1'b0;
        end
        if (((vs1 & align_mask) != '0) || ((vs2 & align_mask) != '0) ||
            ((vd & align_mask) != '0)) begin
            legal = 1'b0;
        end
    end

    always_comb begin
        issue       = (state_q == StIssue);
        is_last     = issue && (idx_q == lmul_m1_q);
        handshake   = issue && out_ready;
        // Accept in the same cycle the last micro-op leaves so groups chain without a bubble.
        in_ready    = !issue || (handshake && is_last);
        accept      = in_valid && in_ready;
        fetch_stall = in_valid && !in_ready;
    end

    always_comb begin
        state_d   = state_q;
        vs1_d     = vs1_q;
        vs2_d     = vs2_q;
        vd_d      = vd_q;
        lmul_m1_d = lmul_m1_q;
        idx_d     = idx_q;
        illegal_d = 1'b0;

        if (accept) begin
            if (legal) begin
                vs1_d     = vs1;
                vs2_d     = vs2;
                vd_d      = vd;
                lmul_m1_d = 3'(lmul_dec - 4'd1);
                idx_d     = 3'd0;
                state_d   = StIssue;
            end else begin
                illegal_d = 1'b1;
                idx_d     = 3'd0;
                state_d   = StIdle;
            end
        end else if (handshake) begin
            if (is_last) begin
                idx_d   = 3'd0;
                state_d = StIdle;
            end else begin
                idx_d = idx_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            vs1_q     <= '0;
            vs2_q     <= '0;
            vd_q      <= '0;
            lmul_m1_q <= 3'd0;
            idx_q     <= 3'd0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            vs1_q     <= vs1_d;
            vs2_q     <= vs2_d;
            vd_q      <= vd_d;
            lmul_m1_q <= lmul_m1_d;
            idx_q     <= idx_d;
            illegal_q <= illegal_d;
        end
    end

    // Outputs read as zero whenever no micro-op is held.
    always_comb begin
        out_valid = issue;
        illegal   = illegal_q;
        uop_idx   = issue ? idx_q : 3'd0;
        uop_first = issue && (idx_q == 3'd0);
        uop_last  = is_last;
        raA_out   = issue ? (vs1_q + REG_W'(idx_q)) : '0;
        raB_out   = issue ? (vs2_q + REG_W'(idx_q)) : '0;
        rdest_out = issue ? (vd_q + REG_W'(idx_q)) : '0;
    end

endmodule

// File: tb/tb_lmul_uop_sequencer.sv
// Directed self-checking bench for lmul_uop_sequencer with hand-computed expectations.
module tb_lmul_uop_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [4:0] vs1, vs2, vd;
    logic [2:0] lmul_enc;
    logic       out_valid;
    logic       out_ready;
    logic [4:0] raA_out, raB_out, rdest_out;
    logic [2:0] uop_idx;
    logic       uop_first, uop_last;
    logic       illegal;
    logic       fetch_stall;

    int n_checks = 0;
    int n_errors = 0;

    lmul_uop_sequencer #(.REG_W(5), .MAX_LMUL(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .vs1        (vs1),
        .vs2        (vs2),
        .vd         (vd),
        .lmul_enc   (lmul_enc),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .raA_out    (raA_out),
        .raB_out    (raB_out),
        .rdest_out  (rdest_out),
        .uop_idx    (uop_idx),
        .uop_first  (uop_first),
        .uop_last   (uop_last),
        .illegal    (illegal),
        .fetch_stall(fetch_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                         input logic [4:0] d, input logic [2:0] enc);
        in_valid = v;
        vs1      = a;
        vs2      = b;
        vd       = d;
        lmul_enc = enc;
    endtask

    task automatic check_uop(input string tag, input logic [4:0] a, input logic [4:0] b,
                             input logic [4:0] d, input logic [2:0] idx, input logic f,
                             input logic l);
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".raA"}, 32'(raA_out), 32'(a));
        check({tag, ".raB"}, 32'(raB_out), 32'(b));
        check({tag, ".rdest"}, 32'(rdest_out), 32'(d));
        check({tag, ".idx"}, 32'(uop_idx), 32'(idx));
        check({tag, ".first"}, 32'(uop_first), 32'(f));
        check({tag, ".last"}, 32'(uop_last), 32'(l));
    endtask

    // Back-to-back stimulus and expected micro-op stream.
    logic [4:0] bb_in [3][3];
    logic [2:0] bb_enc [3];
    logic [4:0] bb_exp [5][3];
    logic [2:0] bb_idx [5];
    logic       bb_f [5];
    logic       bb_l [5];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        int holds;
        int k;
        logic acc;

        bb_in[0] = '{5'd0, 5'd2, 5'd4};   bb_enc[0] = 3'b001;
        bb_in[1] = '{5'd6, 5'd7, 5'd9};   bb_enc[1] = 3'b000;
        bb_in[2] = '{5'd10, 5'd12, 5'd14}; bb_enc[2] = 3'b001;
        bb_exp[0] = '{5'd0, 5'd2, 5'd4};   bb_idx[0] = 3'd0; bb_f[0] = 1; bb_l[0] = 0;
        bb_exp[1] = '{5'd1, 5'd3, 5'd5};   bb_idx[1] = 3'd1; bb_f[1] = 0; bb_l[1] = 1;
        bb_exp[2] = '{5'd6, 5'd7, 5'd9};   bb_idx[2] = 3'd0; bb_f[2] = 1; bb_l[2] = 1;
        bb_exp[3] = '{5'd10, 5'd12, 5'd14}; bb_idx[3] = 3'd0; bb_f[3] = 1; bb_l[3] = 0;
        bb_exp[4] = '{5'd11, 5'd13, 5'd15}; bb_idx[4] = 3'd1; bb_f[4] = 0; bb_l[4] = 1;

        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 5'd0, 5'd0, 5'd0, 3'd0);
        tick();
        tick();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready", 32'(in_ready), 32'd1);
        check("rst.fetch_stall", 32'(fetch_stall), 32'd0);
        check("rst.illegal", 32'(illegal), 32'd0);
        check("rst.rdest", 32'(rdest_out), 32'd0);
        check("rst.idx", 32'(uop_idx), 32'd0);
        check("rst.first", 32'(uop_first), 32'd0);
        check("rst.last", 32'(uop_last), 32'd0);
        reset = 1'b0;

        // LMUL=1
        drive(1'b1, 5'd3, 5'd5, 5'd7, 3'b000);
        #1;
        check("l1.in_ready", 32'(in_ready), 32'd1);
        check("l1.stall", 32'(fetch_stall), 32'd0);
        tick();
        in_valid = 1'b0;
        #1;
        check_uop("l1.uop", 5'd3, 5'd5, 5'd7, 3'd0, 1'b1, 1'b1);
        check("l1.stall1", 32'(fetch_stall), 32'd0);
        tick();
        check("l1.done", 32'(out_valid), 32'd0);

        // LMUL=4 with a second LMUL=2 instruction waiting
        drive(1'b1, 5'd8, 5'd12, 5'd16, 3'b010);
        tick();
        drive(1'b1, 5'd2, 5'd4, 5'd6, 3'b001);
        #1;
        for (int i = 0; i < 4; i++) begin
            check_uop($sformatf("l4.uop%0d", i), 5'(8 + i), 5'(12 + i), 5'(16 + i), 3'(i),
                      (i == 0), (i == 3));
            check($sformatf("l4.stall%0d", i), 32'(fetch_stall), 32'(i < 3));
            check($sformatf("l4.in_ready%0d", i), 32'(in_ready), 32'(i == 3));
            tick();
        end
        in_valid = 1'b0;
        #1;
        check_uop("l4.next0", 5'd2, 5'd4, 5'd6, 3'd0, 1'b1, 1'b0);
        tick();
        check_uop("l4.next1", 5'd3, 5'd5, 5'd7, 3'd1, 1'b0, 1'b1);
        tick();
        check("l4.done", 32'(out_valid), 32'd0);

        // LMUL=8 at vd=24 with out_ready low for two cycles at uop_idx=2
        drive(1'b1, 5'd0, 5'd8, 5'd24, 3'b011);
        tick();
        in_valid = 1'b0;
        e = 0;
        holds = 0;
        for (int c = 0; c < 12 && e < 8; c++) begin
            #1;
            check($sformatf("l8.valid%0d", c), 32'(out_valid), 32'd1);
            check($sformatf("l8.idx%0d", c), 32'(uop_idx), 32'(e));
            check($sformatf("l8.rdest%0d", c), 32'(rdest_out), 32'(24 + e));
            check($sformatf("l8.raB%0d", c), 32'(raB_out), 32'(8 + e));
            if (e == 2 && holds < 2) begin
                out_ready = 1'b0;
                holds++;
            end else begin
                out_ready = 1'b1;
                e++;
            end
            tick();
        end
        out_ready = 1'b1;
        check("l8.count", 32'(e), 32'd8);
        check("l8.done", 32'(out_valid), 32'd0);

        // Misaligned LMUL=2 (vd=3), then reserved encoding 101
        drive(1'b1, 5'd0, 5'd0, 5'd3, 3'b001);
        #1;
        check("mis.in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        check("mis.illegal", 32'(illegal), 32'd1);
        check("mis.valid", 32'(out_valid), 32'd0);
        tick();
        check("mis.illegal_end", 32'(illegal), 32'd0);
        check("mis.valid_end", 32'(out_valid), 32'd0);
        check("mis.in_ready_end", 32'(in_ready), 32'd1);
        drive(1'b1, 5'd0, 5'd0, 5'd0, 3'b101);
        tick();
        in_valid = 1'b0;
        check("rsv.illegal", 32'(illegal), 32'd1);
        check("rsv.valid", 32'(out_valid), 32'd0);
        tick();
        check("rsv.illegal_end", 32'(illegal), 32'd0);
        check("rsv.valid_end", 32'(out_valid), 32'd0);
        check("rsv.in_ready_end", 32'(in_ready), 32'd1);

        // Reset at uop_idx=1 of an LMUL=4 group
        drive(1'b1, 5'd4, 5'd8, 5'd12, 3'b010);
        tick();
        in_valid = 1'b0;
        tick();
        check("rmid.idx", 32'(uop_idx), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rmid.valid", 32'(out_valid), 32'd0);
        check("rmid.in_ready", 32'(in_ready), 32'd1);
        check("rmid.rdest", 32'(rdest_out), 32'd0);
        drive(1'b1, 5'd10, 5'd20, 5'd30, 3'b001);
        tick();
        in_valid = 1'b0;
        #1;
        check_uop("rmid.uop0", 5'd10, 5'd20, 5'd30, 3'd0, 1'b1, 1'b0);
        tick();
        check_uop("rmid.uop1", 5'd11, 5'd21, 5'd31, 3'd1, 1'b0, 1'b1);
        tick();
        check("rmid.done", 32'(out_valid), 32'd0);

        // Back-to-back LMUL=2, LMUL=1, LMUL=2
        k = 0;
        for (int n = 0; n < 5; n++) begin
            if (k < 3) drive(1'b1, bb_in[k][0], bb_in[k][1], bb_in[k][2], bb_enc[k]);
            else in_valid = 1'b0;
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
            check_uop($sformatf("b2b.uop%0d", n), bb_exp[n][0], bb_exp[n][1], bb_exp[n][2],
                      bb_idx[n], bb_f[n], bb_l[n]);
        end
        in_valid = 1'b0;
        check("b2b.accepted", 32'(k), 32'd3);
        tick();
        check("b2b.done", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
